// File: rtl/color_pkg.sv
// Shared colour definitions and scheduler state type for the shared colour output.
package color_pkg;

  localparam int unsigned COLOR_W = 4;
  localparam logic [COLOR_W-1:0] IDLE_COLOR = 4'd0;

  // Colour codes used by the stepping counter.
  localparam logic [COLOR_W-1:0] COLOR_STEP0 = 4'd2;
  localparam logic [COLOR_W-1:0] COLOR_STEP1 = 4'd3;
  localparam logic [COLOR_W-1:0] COLOR_STEP2 = 4'd4;
  localparam logic [COLOR_W-1:0] COLOR_STEP3 = 4'd5;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StRelease
  } state_e;

endpackage

// File: rtl/color_rr_pick.sv
// Combinational round-robin selector: searches upward from last+1 with wrap for the
// first asserted request.
module color_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(idx)]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_scheduler.sv
// Time-shares one registered colour output between requesters: round-robin grant,
// fixed dwell (or abort), one idle-colour release cycle, then back to arbitration.
module color_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COLOR_W = color_pkg::COLOR_W,
  parameter int unsigned DWELL_W = 16,
  parameter logic [COLOR_W-1:0] IDLE_COLOR = COLOR_W'(color_pkg::IDLE_COLOR),
  parameter int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COLOR_W-1:0] req_color,
  input  logic [NUM_REQ*DWELL_W-1:0] req_dwell,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [COLOR_W-1:0]         color,
  output logic                       busy,
  output logic [IDX_W-1:0]           owner
);

  import color_pkg::*;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [COLOR_W-1:0]   color_arr [NUM_REQ];
  logic [DWELL_W-1:0]   dwell_arr [NUM_REQ];
  logic [DWELL_W-1:0]   dwell_sel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign color_arr[i] = req_color[i*COLOR_W +: COLOR_W];
    assign dwell_arr[i] = req_dwell[i*DWELL_W +: DWELL_W];
  end

  color_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (owner_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign dwell_sel = dwell_arr[pick_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    owner_d = owner_q;
    grant_d = '0;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        color_d = IDLE_COLOR;
        if (pick_valid) begin
          color_d           = color_arr[pick_idx];
          // A zero dwell still shows the colour for one cycle.
          cnt_d             = (dwell_sel == '0) ? '0 : dwell_sel - DWELL_W'(1);
          owner_d           = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d           = StShow;
        end
      end
      StShow: begin
        if (cnt_q == '0 || abort) begin
          done_d[owner_q] = 1'b1;
          color_d         = IDLE_COLOR;
          state_d         = StRelease;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      StRelease: begin
        color_d = IDLE_COLOR;
        state_d = StIdle;
      end
      default: begin
        color_d = IDLE_COLOR;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      color_q <= IDLE_COLOR;
      owner_q <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign color = color_q;
  assign grant = grant_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_color_scheduler.sv
// Directed bench for color_scheduler with a timestamp-based schedule model checked every cycle.
module tb_color_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_color = '0;
  logic [63:0] req_dwell = '0;
  logic        abort = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  color;
  logic        busy;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  color_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_color (req_color),
    .req_dwell (req_dwell),
    .abort     (abort),
    .grant     (grant),
    .done      (done),
    .color     (color),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Model: a grant at cycle g_cyc shows m_col through show_end, done lands at show_end+1,
  // busy holds through busy_until; arbitration happens only when the previous cycle was idle.
  longint cyc = 0;
  longint g_cyc, show_end, busy_until;
  int     m_owner;
  logic [3:0] m_col;

  task automatic model_reset();
    g_cyc      = -10;
    show_end   = -20;
    busy_until = -1;
    m_owner    = 3;
    m_col      = 4'd0;
  endtask

  task automatic model_update();
    longint prev;
    int     d;
    cyc++;
    prev = cyc - 1;
    if (rst) begin
      model_reset();
      return;
    end
    if (prev >= g_cyc && prev <= show_end) begin
      if (abort && prev < show_end) begin
        show_end   = prev;
        busy_until = cyc;
      end
    end else if (prev > busy_until && req != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_owner + k) % 4;
        if (req[i]) begin
          m_owner    = i;
          m_col      = req_color[i*4 +: 4];
          d          = int'(req_dwell[i*16 +: 16]);
          if (d == 0) d = 1;
          g_cyc      = cyc;
          show_end   = cyc + d - 1;
          busy_until = cyc + d;
          break;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [3:0] eg, ed, ec;
    eg = (cyc == g_cyc) ? (4'b0001 << m_owner) : 4'b0000;
    ed = (show_end >= g_cyc && cyc == show_end + 1) ? (4'b0001 << m_owner) : 4'b0000;
    ec = (cyc >= g_cyc && cyc <= show_end) ? m_col : 4'd0;
    chk("grant", 32'(grant), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("color", 32'(color), 32'(ec));
    chk("busy", 32'(busy), 32'(cyc <= busy_until));
    chk("owner", 32'(owner), 32'(m_owner));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [15:0] d);
    req_color[i*4 +: 4]   = c;
    req_dwell[i*16 +: 16] = d;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  int gidx[$];
  int gcol[$];
  longint gcyc[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int exp_color[5] = '{2, 3, 4, 5, 2};
  int ncolor;
  int ndone;

  initial begin
    model_reset();

    // Reset held for three cycles with no requests.
    repeat (3) step();
    chk("reset_owner", 32'(owner), 32'd3);
    chk("reset_color", 32'(color), 32'd0);
    rst = 1'b0;
    step();

    // Single request: colour 2 for three cycles.
    set_req(0, 4'd2, 16'd3);
    req = 4'b0001;
    step();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_color", 32'(color), 32'd2);
    req = 4'b0000;
    step();
    step();
    chk("single_color_last", 32'(color), 32'd2);
    step();
    chk("single_done", 32'(done), 32'h1);
    chk("single_done_color", 32'(color), 32'd0);
    chk("single_release_busy", 32'(busy), 32'd1);
    step();
    chk("single_busy_low", 32'(busy), 32'd0);

    // Round-robin fairness after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 4'd2, 16'd1);
    set_req(1, 4'd3, 16'd1);
    set_req(2, 4'd4, 16'd1);
    set_req(3, 4'd5, 16'd1);
    req = 4'b1111;
    for (int n = 0; n < 40 && gidx.size() < 5; n++) begin
      step();
      if (grant != 4'd0) begin
        gidx.push_back(oh_idx(grant));
        gcol.push_back(int'(color));
        gcyc.push_back(cyc);
      end
    end
    req = 4'b0000;
    chk("rr_count", 32'(gidx.size()), 32'd5);
    for (int i = 0; i < gidx.size() && i < 5; i++) begin
      chk("rr_order", 32'(gidx[i]), 32'(exp_order[i]));
      chk("rr_color", 32'(gcol[i]), 32'(exp_color[i]));
      if (i > 0) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    drain();

    // Abort while idle does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Zero dwell shows exactly one cycle.
    set_req(1, 4'd3, 16'd0);
    req = 4'b0010;
    step();
    chk("zero_grant", 32'(grant), 32'h2);
    chk("zero_color", 32'(color), 32'd3);
    req = 4'b0000;
    step();
    chk("zero_done", 32'(done), 32'h2);
    chk("zero_color_off", 32'(color), 32'd0);
    drain();

    // Long dwell aborted during its fifth shown cycle.
    set_req(2, 4'd4, 16'd100);
    req = 4'b0100;
    step();
    req = 4'b0000;
    ncolor = (color == 4'd4) ? 1 : 0;
    repeat (4) begin
      step();
      if (color == 4'd4) ncolor++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'h4);
    chk("abort_color", 32'(color), 32'd0);
    chk("abort_shown_cycles", 32'(ncolor), 32'd5);
    drain();

    // Abort coinciding with the final dwell cycle yields one done.
    set_req(3, 4'd5, 16'd2);
    req = 4'b1000;
    step();
    req = 4'b0000;
    step();
    abort = 1'b1;
    ndone = 0;
    step();
    abort = 1'b0;
    if (done != 4'd0) ndone++;
    repeat (3) begin
      step();
      if (done != 4'd0) ndone++;
    end
    chk("abort_final_single_done", 32'(ndone), 32'd1);

    // Reset during requester 2's dwell discards it.
    set_req(0, 4'd2, 16'd4);
    set_req(2, 4'd4, 16'd100);
    req = 4'b0100;
    step();
    req = 4'b0000;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("midrst_color", 32'(color), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    step();
    step();
    rst = 1'b0;
    req = 4'b0101;
    step();
    chk("midrst_first_grant", 32'(grant), 32'h1);
    req = 4'b0100;
    ndone = 0;
    for (int n = 0; n < 20 && ndone == 0; n++) begin
      step();
      if (grant[2]) ndone = 1;
    end
    chk("midrst_second_grant", 32'(ndone), 32'd1);
    req = 4'b0000;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_scheduler.md
# color_scheduler

Time-shares the single 4-bit `color` output between up to NUM_REQ requesters, such as the colour stepping counter, status indicators and test patterns. Each requester asks for a colour and a dwell time in clock cycles. The block grants requesters round-robin and drives the granted colour for exactly that many cycles. It then returns the output to the idle colour and reports completion.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- COLOR_W, 4, colour code width
- DWELL_W, 16, dwell counter width
- IDLE_COLOR, 0, colour driven when no requester owns the output
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester request level; held until grant
- req_color  in  NUM_REQ*COLOR_W  packed colours, requester i at bits [i*COLOR_W +: COLOR_W]
- req_dwell  in  NUM_REQ*DWELL_W  packed dwell counts, same packing
- abort  in  1  ends the current dwell early
- grant  out  NUM_REQ  one-hot, one-cycle pulse on acceptance
- done  out  NUM_REQ  one-hot, one-cycle pulse when the owner's dwell ends
- color  out  COLOR_W  registered shared colour output
- busy  out  1  high while the output is owned or releasing
- owner  out  $clog2(NUM_REQ)  index of the current/last owner

## Operation
- States:
  - IDLE: no owner.
  - SHOW: the owner's colour is driven.
  - RELEASE: one idle-colour gap cycle.
- IDLE, any req high:
  - Select winner i by round-robin, searching from (owner+1) mod NUM_REQ upward with wrap.
  - Latch req_color[i] into color.
  - Load the dwell counter with dwell_eff-1, where dwell_eff = max(req_dwell[i], 1); a dwell of 0 is treated as 1.
  - Set owner=i, pulse grant[i], set busy=1, go to SHOW.
- IDLE, no req: hold; color=IDLE_COLOR, busy=0.
- SHOW, counter==0 or abort=1:
  - Pulse done[owner], color=IDLE_COLOR, go to RELEASE.
  - If abort and counter==0 occur together, produce one done pulse only.
- SHOW, otherwise: decrement the counter; color holds.
- Non-preemptive: req changes, req_color changes and req_dwell changes during SHOW are ignored; they affect only the next arbitration.
- RELEASE: go to IDLE; busy=0 from the next cycle.
- abort outside SHOW has no effect.
- Reset values (async, immediate):
  - color=IDLE_COLOR, grant=0, done=0, busy=0.
  - owner=NUM_REQ-1, so requester 0 wins first after reset.
  - Counter=0, state IDLE.
- Reset mid-SHOW: the dwell is discarded and no done is issued.
- Counter width is DWELL_W and it never wraps; it only decrements from a loaded value down to 0.

## Timing
- Request sampled high in IDLE at cycle t:
  - grant[i], color and busy are visible at t+1.
  - Colour is driven for cycles t+1 .. t+dwell_eff.
  - done[i] and IDLE_COLOR appear at t+dwell_eff+1 (RELEASE).
  - State is IDLE at t+dwell_eff+2; the earliest next grant is visible at t+dwell_eff+3.
- abort sampled in SHOW at cycle s: done and IDLE_COLOR appear at s+1.
- Back-to-back service spacing between grants is dwell_eff+2 cycles.
- grant and done are never high in the same cycle, and each is at most one-hot.
- No combinational path from any input to any output.

## Structure
- Shared package `color_pkg`:
  - COLOR_W and IDLE_COLOR constants.
  - Enumerated state type (IDLE, SHOW, RELEASE).
  - Named colour codes 2..5, as used by the stepping counter.
- Sub-module `color_rr_pick`:
  - Combinational round-robin selector.
  - Inputs: req vector and last owner index.
  - Outputs: winner index and a valid flag.
  - Reusable by other shared-output arbiters.
- Top holds the FSM, the dwell counter and the output registers.

## Test plan
- Reset then idle: hold rst for 3 cycles with req=0.
  - Expect color=0, busy=0, owner=3, grant=done=0 throughout.
- Single request: req=0001, req_color[0]=2, dwell=3.
  - Expect grant[0] at t+1.
  - Expect color=2 for 3 cycles, then done[0] with color=0.
  - Expect busy low 2 cycles after the last colour cycle.
- Round-robin fairness: req=1111, colours 2/3/4/5, dwell=1 each.
  - Expect grant order 0,1,2,3,0 with color sequence 2,3,4,5,2.
  - Expect grants spaced 3 cycles apart.
- Zero dwell and abort:
  - req[1] with dwell=0 shows color for exactly 1 cycle.
  - req[2] with dwell=100 and abort at the 5th SHOW cycle gives done[2] next cycle and color=0.
  - abort coinciding with the final dwell cycle gives a single done.
- Reset mid-operation: assert rst during SHOW of requester 2.
  - Expect color=0, busy=0 and no done immediately.
  - After release, requester 0 wins first when req=0101.
